// File: rtl/packet_encode_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : packet_encode_fsm
//  Brief    : Transmit-side framer. Emits SOP, command, length and payload
//             words on a valid/ready link, plus an optional RESYNC word.
//             Build option: PACKET_ENCODE_RESYNC_EN enables RESYNC handling.
//  Revision : 1.0  initial release
// ============================================================================
module packet_encode_fsm (
    input  wire logic        i_clk,
    input  wire logic        i_reset_n,
    input  wire logic        i_start,
    input  wire logic [1:0]  i_command,
    input  wire logic [31:0] i_num_words,
    input  wire logic        i_resync,
    input  wire logic [31:0] i_payload_word,
    input  wire logic        i_payload_valid,
    output logic             o_payload_ready,
    output logic [31:0]      o_tx_word,
    output logic             o_tx_valid,
    input  wire logic        i_tx_ready,
    output logic             o_busy,
    output logic             o_packet_done,
    output logic             o_start_err
);

    localparam logic [31:0] C_SOP_WORD    = 32'h741B8CD7;
    localparam logic [31:0] C_RESYNC_WORD = 32'h1EDC6F41;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SOP     = 3'd1,
        S_CMD     = 3'd2,
        S_LEN     = 3'd3,
        S_PAYLOAD = 3'd4,
        S_DRAIN   = 3'd5,
        S_RESYNC  = 3'd6
    } state_t;

    state_t      r_state;
    logic [31:0] r_tx_word;
    logic        r_tx_valid;
    logic [1:0]  r_cmd;
    logic [31:0] r_count;
    logic        r_packet_done;
    logic        r_start_err;

    logic        w_xfer;
    logic        w_load_ok;
    logic        w_payload_ready;
    logic        w_pay_take;
    logic        w_pend;
    logic        w_resync_req;
    logic        w_resync_go;

`ifdef PACKET_ENCODE_RESYNC_EN
    logic        r_resync_pend;

    assign w_pend       = r_resync_pend;
    assign w_resync_req = i_resync;
    // A pending RESYNC pre-empts whatever the FSM would load next.
    assign w_resync_go  = r_resync_pend && w_load_ok && (r_state != S_RESYNC);
`else
    logic        w_unused_resync;

    assign w_unused_resync = i_resync;
    assign w_pend          = 1'b0;
    assign w_resync_req    = 1'b0;
    assign w_resync_go     = 1'b0;
`endif

    assign w_xfer          = r_tx_valid && i_tx_ready;
    assign w_load_ok       = !r_tx_valid || i_tx_ready;
    // Hold off the FIFO once a RESYNC is pending so unsent words stay queued.
    assign w_payload_ready = (r_state == S_PAYLOAD) && w_load_ok && !w_pend;
    assign w_pay_take      = w_payload_ready && i_payload_valid;

    assign o_payload_ready = w_payload_ready;
    assign o_tx_word       = r_tx_word;
    assign o_tx_valid      = r_tx_valid;
    assign o_busy          = (r_state != S_IDLE);
    assign o_packet_done   = r_packet_done;
    assign o_start_err     = r_start_err;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_tx_word     <= 32'h0;
            r_tx_valid    <= 1'b0;
            r_cmd         <= 2'b00;
            r_count       <= 32'h0;
            r_packet_done <= 1'b0;
            r_start_err   <= 1'b0;
`ifdef PACKET_ENCODE_RESYNC_EN
            r_resync_pend <= 1'b0;
`endif
        end else begin
            r_packet_done <= 1'b0;
            r_start_err   <= 1'b0;
            if (w_xfer) begin
                r_tx_valid <= 1'b0;
            end
`ifdef PACKET_ENCODE_RESYNC_EN
            if (i_resync) begin
                r_resync_pend <= 1'b1;
            end
`endif
            if (w_resync_go) begin
                r_tx_word  <= C_RESYNC_WORD;
                r_tx_valid <= 1'b1;
                r_count    <= 32'h0;
                r_state    <= S_RESYNC;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start && !w_resync_req && !w_pend) begin
                            if (i_num_words != 32'h0) begin
                                r_cmd   <= i_command;
                                r_count <= i_num_words;
                                r_state <= S_SOP;
                            end else begin
                                r_start_err <= 1'b1;
                            end
                        end
                    end
                    S_SOP: begin
                        if (w_load_ok) begin
                            r_tx_word  <= C_SOP_WORD;
                            r_tx_valid <= 1'b1;
                            r_state    <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        if (w_load_ok) begin
                            r_tx_word  <= {6'b0, r_cmd, 24'h0};
                            r_tx_valid <= 1'b1;
                            r_state    <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (w_load_ok) begin
                            r_tx_word  <= {r_count[7:0], r_count[15:8],
                                           r_count[23:16], r_count[31:24]};
                            r_tx_valid <= 1'b1;
                            r_state    <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: begin
                        if (w_pay_take) begin
                            r_tx_word  <= i_payload_word;
                            r_tx_valid <= 1'b1;
                            r_count    <= r_count - 32'd1;
                            if (r_count == 32'd1) begin
                                r_state <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_xfer) begin
                            r_packet_done <= 1'b1;
                            r_state       <= S_IDLE;
                        end
                    end
`ifdef PACKET_ENCODE_RESYNC_EN
                    S_RESYNC: begin
                        if (w_xfer) begin
                            r_resync_pend <= 1'b0;
                            r_state       <= S_IDLE;
                        end
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_packet_encode_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_packet_encode_fsm
//  Brief    : Self-checking bench for packet_encode_fsm; RESYNC sequences are
//             exercised when PACKET_ENCODE_RESYNC_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_packet_encode_fsm;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_start;
    logic [1:0]  i_command;
    logic [31:0] i_num_words;
    logic        i_resync;
    logic [31:0] i_payload_word;
    logic        i_payload_valid;
    logic        o_payload_ready;
    logic [31:0] o_tx_word;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_packet_done;
    logic        o_start_err;

    localparam logic [31:0] C_SOP    = 32'h741B8CD7;
    localparam logic [31:0] C_RESYNC = 32'h1EDC6F41;

    packet_encode_fsm u_dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_start         (i_start),
        .i_command       (i_command),
        .i_num_words     (i_num_words),
        .i_resync        (i_resync),
        .i_payload_word  (i_payload_word),
        .i_payload_valid (i_payload_valid),
        .o_payload_ready (o_payload_ready),
        .o_tx_word       (o_tx_word),
        .o_tx_valid      (o_tx_valid),
        .i_tx_ready      (i_tx_ready),
        .o_busy          (o_busy),
        .o_packet_done   (o_packet_done),
        .o_start_err     (o_start_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] n;
        logic [31:0] exp_cmd;
        logic [31:0] exp_len;
        bit          stall;
    } vec_t;

    vec_t        vecs [5];
    int          errors;
    int          checks;
    int          cyc;
    int          rd;
    int          xfers;
    int          dones;
    int          first_xfer;
    int          last_xfer;
    bit          prev_stall;
    logic [31:0] prev_word;
    bit          busy_at_done;
    logic [31:0] exp_q [$];
    logic [31:0] fifo [0:511];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit rnd_ready(input bit stall);
        return stall ? (($urandom % 3) != 0) : 1'b1;
    endfunction

    function automatic bit rnd_valid(input bit stall);
        return stall ? (($urandom % 4) != 0) : 1'b1;
    endfunction

    // Reference length word built arithmetically from the count's byte values.
    function automatic logic [31:0] ref_len(input logic [31:0] n);
        return ((n % 256) << 24) + (((n / 256) % 256) << 16)
             + (((n / 65536) % 256) << 8) + (n / 16777216);
    endfunction

    // Drive one cycle of inputs, observe outputs, then advance past the edge.
    task automatic step(input bit rdy, input bit pv, input bit rs, input bit st,
                        input logic [1:0] cmd, input logic [31:0] n);
        i_tx_ready      = rdy;
        i_payload_valid = pv;
        i_payload_word  = fifo[rd % 512];
        i_resync        = rs;
        i_start         = st;
        i_command       = cmd;
        i_num_words     = n;
        #1;
        if (prev_stall) begin
            chk("stall_valid_held", 32'(o_tx_valid), 32'd1);
            chk("stall_word_stable", o_tx_word, prev_word);
        end
        if (o_tx_valid && i_tx_ready) begin
            xfers++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            if (exp_q.size() == 0) begin
                chk("extra_word", o_tx_word, 32'hxxxxxxxx);
            end else begin
                chk("tx_word", o_tx_word, exp_q.pop_front());
            end
        end
        if (o_payload_ready && i_payload_valid) rd++;
        if (o_packet_done) begin
            dones++;
            busy_at_done = o_busy;
            chk("done_timing", 32'(cyc), 32'(last_xfer + 1));
        end
        prev_stall = o_tx_valid && !i_tx_ready;
        prev_word  = o_tx_word;
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic init_pkt(input logic [1:0] cmd, input logic [31:0] n,
                            input logic [31:0] exp_cmd, input logic [31:0] exp_len);
        rd = 0; xfers = 0; dones = 0; first_xfer = -1; last_xfer = -10;
        busy_at_done = 1'b1;
        exp_q.delete();
        exp_q.push_back(C_SOP);
        exp_q.push_back(exp_cmd);
        exp_q.push_back(exp_len);
        for (int i = 0; i < int'(n); i++) begin
            fifo[i] = $urandom;
            exp_q.push_back(fifo[i]);
        end
    endtask

    task automatic run_packet(input logic [1:0] cmd, input logic [31:0] n,
                              input logic [31:0] exp_cmd, input logic [31:0] exp_len,
                              input bit stall);
        int start_cyc;
        int budget;
        init_pkt(cmd, n, exp_cmd, exp_len);
        start_cyc = cyc;
        budget    = 20 * int'(n) + 100;
        step(rnd_ready(stall), rnd_valid(stall), 1'b0, 1'b1, cmd, n);
        chk("busy_after_start", 32'(o_busy), 32'd1);
        while (dones == 0 && (cyc - start_cyc) < budget)
            step(rnd_ready(stall), rnd_valid(stall), 1'b0, 1'b0, 2'd0, 32'd0);
        chk("done_seen", 32'(dones), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("done_once", 32'(dones), 32'd1);
        chk("words_left", 32'(exp_q.size()), 32'd0);
        chk("payload_consumed", 32'(rd), n);
        chk("busy_at_done", 32'(busy_at_done), 32'd0);
        chk("idle_after", 32'(o_busy), 32'd0);
        if (!stall) begin
            chk("first_latency", 32'(first_xfer - start_cyc), 32'd2);
            chk("burst_span", 32'(last_xfer - first_xfer), n + 32'd2);
        end
    endtask

    task automatic zero_start(input logic [1:0] cmd);
        exp_q.delete();
        xfers = 0;
        step(1'b1, 1'b1, 1'b0, 1'b1, cmd, 32'd0);
        chk("start_err_pulse", 32'(o_start_err), 32'd1);
        chk("zero_busy", 32'(o_busy), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("start_err_clear", 32'(o_start_err), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("zero_no_words", 32'(xfers), 32'd0);
    endtask

    initial begin
        logic [1:0]  rc;
        logic [31:0] rn;

        errors = 0; checks = 0; cyc = 0; rd = 0; prev_stall = 1'b0; prev_word = 32'h0;
        xfers = 0; dones = 0; first_xfer = -1; last_xfer = -10; busy_at_done = 1'b0;
        for (int i = 0; i < 512; i++) fifo[i] = 32'h0;

        vecs[0] = '{cmd: 2'd2, n: 32'd3,   exp_cmd: 32'h02000000, exp_len: 32'h03000000, stall: 1'b0};
        vecs[1] = '{cmd: 2'd1, n: 32'd1,   exp_cmd: 32'h01000000, exp_len: 32'h01000000, stall: 1'b0};
        vecs[2] = '{cmd: 2'd3, n: 32'h102, exp_cmd: 32'h03000000, exp_len: 32'h02010000, stall: 1'b1};
        vecs[3] = '{cmd: 2'd0, n: 32'd5,   exp_cmd: 32'h00000000, exp_len: 32'h05000000, stall: 1'b1};
        vecs[4] = '{cmd: 2'd1, n: 32'd0,   exp_cmd: 32'h01000000, exp_len: 32'h00000000, stall: 1'b0};

        i_reset_n = 1'b0; i_start = 1'b0; i_command = 2'd0; i_num_words = 32'd0;
        i_resync = 1'b0; i_payload_word = 32'h0; i_payload_valid = 1'b0; i_tx_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_tx_word", o_tx_word, 32'h0);
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_packet_done), 32'd0);
        chk("rst_err", 32'(o_start_err), 32'd0);
        chk("rst_pready", 32'(o_payload_ready), 32'd0);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Idle with toggling ready: nothing may transfer.
        exp_q.delete();
        xfers = 0;
        for (int i = 0; i < 6; i++) step(bit'(i % 2), 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("idle_no_xfer", 32'(xfers), 32'd0);
        chk("idle_pready", 32'(o_payload_ready), 32'd0);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].n == 32'd0) zero_start(vecs[v].cmd);
            else run_packet(vecs[v].cmd, vecs[v].n, vecs[v].exp_cmd, vecs[v].exp_len, vecs[v].stall);
        end

        for (int i = 0; i < 4; i++) begin
            rc = 2'($urandom % 4);
            rn = 32'($urandom_range(1, 20));
            run_packet(rc, rn, {6'b0, rc, 24'h0}, ref_len(rn), bit'(i % 2));
        end

        // Reset asserted while the length word is next to go out.
        init_pkt(2'd2, 32'd4, 32'h02000000, 32'h04000000);
        void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
        void'(exp_q.pop_back()); void'(exp_q.pop_back()); void'(exp_q.pop_back());
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 32'd4);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("prerst_busy", 32'(o_busy), 32'd1);
        chk("prerst_word", o_tx_word, 32'h02000000);
        i_reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_tx_valid), 32'd0);
        chk("midrst_word", o_tx_word, 32'h0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset_n  = 1'b1;
        prev_stall = 1'b0;
        run_packet(2'd3, 32'd2, 32'h03000000, 32'h02000000, 1'b0);

`ifdef PACKET_ENCODE_RESYNC_EN
        // RESYNC mid-payload with the output register stalled.
        init_pkt(2'd1, 32'd10, 32'h01000000, 32'h0A000000);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        exp_q.push_back(C_RESYNC);
        step(1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 32'd10);
        for (int g = 0; g < 20 && rd < 3; g++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("rs_stall_word", o_tx_word, fifo[2]);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("rs_words_left", 32'(exp_q.size()), 32'd0);
        chk("rs_no_done", 32'(dones), 32'd0);
        chk("rs_fifo_kept", 32'(rd), 32'd3);
        chk("rs_idle", 32'(o_busy), 32'd0);

        // RESYNC and start together in IDLE: only RESYNC goes out.
        exp_q.delete();
        exp_q.push_back(C_RESYNC);
        dones = 0;
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 32'd3);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
        chk("rs_prio_sent", 32'(exp_q.size()), 32'd0);
        chk("rs_prio_idle", 32'(o_busy), 32'd0);
`else
        exp_q.delete();
        xfers = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        chk("rs_ignored_xfer", 32'(xfers), 32'd0);
        chk("rs_ignored_busy", 32'(o_busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
